// File: rtl/inst_if_pkg.sv
// inst_if_pkg: shared types and constants for the instruction SRAM-like bus interface
//   state_t                 : transaction FSM states (IDLE, REQ, WAIT, DONE)
//   INST_SIZE_WORD          : bus transfer size for a 32-bit word
//   INST_NOP                : instruction word delivered on misaligned fetch or timeout
//   TIMEOUT_CYCLES_DEFAULT  : default bus wait limit in cycles
package inst_if_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    localparam logic [1:0] INST_SIZE_WORD = 2'b10;
    localparam logic [31:0] INST_NOP = 32'h0;
    localparam int TIMEOUT_CYCLES_DEFAULT = 255;
endpackage

// File: rtl/inst_if_watchdog.sv
// inst_if_watchdog: bus wait counter that flags an outstanding fetch running too long
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (a new transaction is entering REQ)
//   count_en   : a transaction is outstanding (REQ or WAIT)
//   expired    : this cycle is the last one allowed; the FSM abandons the fetch
module inst_if_watchdog import inst_if_pkg::*; #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    logic [7:0] count;
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (count_en) count <= count + 8'd1;
    end
    // Flag while the count is about to reach the limit so that exactly
    // TIMEOUT_CYCLES cycles are spent in REQ/WAIT before DONE.
    assign expired = count_en && (count >= 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/inst_sram_interface.sv
// inst_sram_interface: services inst_cache misses over an SRAM-like bus, one fetch at a time
//   clk, reset              : clock, synchronous active-high reset
//   interface_enable/PC     : miss request and fetch address from inst_cache
//   this_time_pc            : address of the instruction presented this cycle
//   interface_instruction   : fetched instruction word
//   cache_wait_stop_choke   : stall to inst_cache, 1 = data not ready
//   inst_req/wr/size/addr   : bus request channel (read-only, word size)
//   inst_addr_ok/data_ok    : bus address accept / read data valid, inst_rdata read data
//   inst_addr_err           : one-cycle pulse on misaligned fetch
//   inst_timeout            : one-cycle pulse on bus timeout
//   Optional feature macro INST_IF_TIMEOUT_EN enables the bus watchdog.
module inst_sram_interface import inst_if_pkg::*; #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interface_enable,
    input  logic [31:0] interface_PC,
    output logic [31:0] this_time_pc,
    output logic [31:0] interface_instruction,
    output logic        cache_wait_stop_choke,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        inst_addr_err,
    output logic        inst_timeout
);
    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        expired;
    logic        start;
    logic        misaligned;
    logic        timeout_hit;

    assign start      = (state == IDLE) && interface_enable;
    assign misaligned = |interface_PC[1:0];
    // A handshake in the expiring cycle still completes normally.
    assign timeout_hit = expired && ((state == REQ && !inst_addr_ok) || (state == WAIT && !inst_data_ok));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= start && misaligned;
            case (state)
                IDLE: if (interface_enable) begin
                    pc_q <= interface_PC;
                    if (misaligned) begin
                        rdata_q <= INST_NOP;
                        state   <= DONE;
                    end else begin
                        state <= REQ;
                    end
                end
                REQ: if (inst_addr_ok && inst_data_ok) begin
                    rdata_q <= inst_rdata;
                    state   <= DONE;
                end else if (inst_addr_ok) begin
                    state <= WAIT;
                end else if (timeout_hit) begin
                    rdata_q <= INST_NOP;
                    state   <= DONE;
                end
                WAIT: if (inst_data_ok) begin
                    rdata_q <= inst_rdata;
                    state   <= DONE;
                end else if (timeout_hit) begin
                    rdata_q <= INST_NOP;
                    state   <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    assign inst_wr               = 1'b0;
    assign inst_size             = INST_SIZE_WORD;
    assign inst_addr             = pc_q;
    assign inst_req              = !reset && (state == REQ);
    assign inst_addr_err         = !reset && err_q;
    assign this_time_pc          = (state == DONE) ? pc_q : interface_PC;
    assign interface_instruction = rdata_q;
    assign cache_wait_stop_choke = reset ? 1'b0 : (state == IDLE) ? interface_enable : (state != DONE);

`ifdef INST_IF_TIMEOUT_EN
    logic to_q;
    inst_if_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (start && !misaligned),
        .count_en (state == REQ || state == WAIT),
        .expired  (expired)
    );
    // Registered so the pulse lands in the DONE cycle that follows the expiry.
    always_ff @(posedge clk) to_q <= !reset && timeout_hit;
    assign inst_timeout = !reset && to_q;
`else
    assign expired      = 1'b0;
    assign inst_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_inst_sram_interface.sv
// tb_inst_sram_interface: table-driven check of the instruction bus interface
module tb_inst_sram_interface;
    import inst_if_pkg::*;

    logic        clk = 1'b0;
    logic        reset, interface_enable, inst_addr_ok, inst_data_ok;
    logic [31:0] interface_PC, inst_rdata;
    logic [31:0] this_time_pc, interface_instruction, inst_addr;
    logic        cache_wait_stop_choke, inst_req, inst_wr, inst_addr_err, inst_timeout;
    logic [1:0]  inst_size;

    int checks = 0;
    int errors = 0;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic rst, en; logic [31:0] pc; logic aok, dok; logic [31:0] rd;
        logic req, choke; logic [31:0] tpc, ins, addr; logic err;
    } vec_t;
    vec_t tbl[$];

    inst_sram_interface #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .interface_enable(interface_enable), .interface_PC(interface_PC),
        .this_time_pc(this_time_pc), .interface_instruction(interface_instruction),
        .cache_wait_stop_choke(cache_wait_stop_choke), .inst_req(inst_req), .inst_wr(inst_wr),
        .inst_size(inst_size), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_addr_err(inst_addr_err),
        .inst_timeout(inst_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, i, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic en, input logic [31:0] pc, input logic aok, input logic dok,
                       input logic [31:0] rd, input logic req, input logic choke, input logic [31:0] tpc,
                       input logic [31:0] ins, input logic [31:0] addr, input logic err);
        vec_t v;
        v = '{rst, en, pc, aok, dok, rd, req, choke, tpc, ins, addr, err};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic en, input logic [31:0] pc, input logic aok,
                         input logic dok, input logic [31:0] rd);
        @(negedge clk);
        reset = rst; interface_enable = en; interface_PC = pc;
        inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
        #1;
    endtask

    initial begin
        // 0: reset held; 1-5: miss with addr_ok then data_ok two cycles later, PC changes ignored
        add(H,H,32'h00400010,L,L,32'h0,        L,L,32'h00400010,32'h0,        32'h0,       L);
        add(L,H,32'h00400010,L,L,32'h0,        L,H,32'h00400010,32'h0,        32'h0,       L);
        add(L,H,32'h00400010,H,L,32'h0,        H,H,32'h00400010,32'h0,        32'h00400010,L);
        add(L,L,32'h11111110,L,L,32'h0,        L,H,32'h11111110,32'h0,        32'h0,       L);
        add(L,L,32'h11111110,L,H,32'h3C1D0040, L,H,32'h11111110,32'h0,        32'h0,       L);
        add(L,L,32'h0,       L,L,32'h0,        L,L,32'h00400010,32'h3C1D0040, 32'h0,       L);
        // 6: data_ok in IDLE ignored; 7-10: addr_ok+data_ok together
        add(L,L,32'h00400020,L,H,32'hDEADBEEF, L,L,32'h00400020,32'h3C1D0040, 32'h0,       L);
        add(L,H,32'h00400020,L,L,32'h0,        L,H,32'h00400020,32'h3C1D0040, 32'h0,       L);
        add(L,H,32'h00400020,H,H,32'h27BDFFE8, H,H,32'h00400020,32'h3C1D0040, 32'h00400020,L);
        add(L,L,32'h00400020,L,L,32'h0,        L,L,32'h00400020,32'h27BDFFE8, 32'h0,       L);
        add(L,L,32'h00400020,L,L,32'h0,        L,L,32'h00400020,32'h27BDFFE8, 32'h0,       L);
        // 11-16: data_ok in REQ without addr_ok ignored, PC change in REQ ignored, data_ok in DONE ignored
        add(L,H,32'h00400030,L,L,32'h0,        L,H,32'h00400030,32'h27BDFFE8, 32'h0,       L);
        add(L,L,32'h99999990,L,H,32'hBAD0BAD0, H,H,32'h99999990,32'h27BDFFE8, 32'h00400030,L);
        add(L,L,32'h99999990,H,L,32'h0,        H,H,32'h99999990,32'h27BDFFE8, 32'h00400030,L);
        add(L,L,32'h00400030,L,H,32'h24020001, L,H,32'h00400030,32'h27BDFFE8, 32'h0,       L);
        add(L,L,32'h0,       L,H,32'hFFFFFFFF, L,L,32'h00400030,32'h24020001, 32'h0,       L);
        add(L,L,32'h0,       L,L,32'h0,        L,L,32'h0,       32'h24020001, 32'h0,       L);
        // 17-19: misaligned PC
        add(L,H,32'h00400022,L,L,32'h0,        L,H,32'h00400022,32'h24020001, 32'h0,       L);
        add(L,L,32'h0,       L,L,32'h0,        L,L,32'h00400022,32'h0,        32'h0,       H);
        add(L,L,32'h0,       L,L,32'h0,        L,L,32'h0,       32'h0,        32'h0,       L);
        // 20-22: refill rdata_q; 23-27: reset in WAIT then late data_ok
        add(L,H,32'h00400060,L,L,32'h0,        L,H,32'h00400060,32'h0,        32'h0,       L);
        add(L,H,32'h00400060,H,H,32'h8FBF0014, H,H,32'h00400060,32'h0,        32'h00400060,L);
        add(L,L,32'h00400060,L,L,32'h0,        L,L,32'h00400060,32'h8FBF0014, 32'h0,       L);
        add(L,H,32'h00400040,L,L,32'h0,        L,H,32'h00400040,32'h8FBF0014, 32'h0,       L);
        add(L,L,32'h00400040,H,L,32'h0,        H,H,32'h00400040,32'h8FBF0014, 32'h00400040,L);
        add(H,L,32'h00400040,L,L,32'h0,        L,L,32'h00400040,32'h8FBF0014, 32'h0,       L);
        add(L,L,32'h00400040,L,H,32'h12345678, L,L,32'h00400040,32'h0,        32'h0,       L);
        add(L,L,32'h00400040,L,L,32'h0,        L,L,32'h00400040,32'h0,        32'h0,       L);

        drive(H, L, 32'h0, L, L, 32'h0);
        drive(H, L, 32'h0, L, L, 32'h0);
        chk("rst_req", 0, 32'(inst_req), 32'h0);
        chk("rst_choke", 0, 32'(cache_wait_stop_choke), 32'h0);
        chk("rst_instr", 0, interface_instruction, 32'h0);
        chk("rst_err", 0, 32'(inst_addr_err), 32'h0);
        chk("rst_timeout", 0, 32'(inst_timeout), 32'h0);
        chk("inst_wr", 0, 32'(inst_wr), 32'h0);
        chk("inst_size", 0, 32'(inst_size), 32'h2);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].pc, tbl[i].aok, tbl[i].dok, tbl[i].rd);
            chk("req", i, 32'(inst_req), 32'(tbl[i].req));
            chk("choke", i, 32'(cache_wait_stop_choke), 32'(tbl[i].choke));
            chk("this_time_pc", i, this_time_pc, tbl[i].tpc);
            chk("instruction", i, interface_instruction, tbl[i].ins);
            chk("addr_err", i, 32'(inst_addr_err), 32'(tbl[i].err));
            chk("timeout", i, 32'(inst_timeout), 32'h0);
            if (tbl[i].req) chk("inst_addr", i, inst_addr, tbl[i].addr);
        end

        // quick fetch so the timeout's NOP is distinguishable from old data
        drive(L, H, 32'h00400070, L, L, 32'h0);
        drive(L, L, 32'h00400070, H, H, 32'hAAAA5555);
        drive(L, L, 32'h00400070, L, L, 32'h0);
        chk("pre_to_instr", 0, interface_instruction, 32'hAAAA5555);
        drive(L, H, 32'h00400080, L, L, 32'h0);
`ifdef INST_IF_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            drive(L, L, 32'h00400080, L, L, 32'h0);
            chk("to_req", k, 32'(inst_req), 32'h1);
            chk("to_early", k, 32'(inst_timeout), 32'h0);
        end
        drive(L, L, 32'h0, L, L, 32'h0);
        chk("to_pulse", 0, 32'(inst_timeout), 32'h1);
        chk("to_instr", 0, interface_instruction, 32'h0);
        chk("to_choke", 0, 32'(cache_wait_stop_choke), 32'h0);
        chk("to_pc", 0, this_time_pc, 32'h00400080);
        chk("to_req_done", 0, 32'(inst_req), 32'h0);
        drive(L, L, 32'h0, L, L, 32'h0);
        chk("to_after", 0, 32'(inst_timeout), 32'h0);
`else
        for (int k = 1; k <= 105; k++) begin
            drive(L, L, 32'h00400080, L, L, 32'h0);
            chk("hold_req", k, 32'(inst_req), 32'h1);
        end
        chk("hold_timeout", 0, 32'(inst_timeout), 32'h0);
        chk("hold_choke", 0, 32'(cache_wait_stop_choke), 32'h1);
        drive(H, L, 32'h0, L, L, 32'h0);
        drive(L, L, 32'h0, L, L, 32'h0);
        chk("hold_reset", 0, 32'(inst_req), 32'h0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_sram_interface.md
INST_SRAM_INTERFACE -- requirements
Module: inst_sram_interface

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, is the bus wait limit in cycles; valid range 1..255.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 interface_enable  in  1  inst_cache miss request.
REQ-006 interface_PC  in  32  fetch address from inst_cache.
REQ-007 this_time_pc  out  32  address of the instruction presented this cycle.
REQ-008 interface_instruction  out  32  fetched instruction word.
REQ-009 cache_wait_stop_choke  out  1  stall to inst_cache; 1 = data not ready.
REQ-010 inst_req  out  1  bus request; inst_wr  out  1  constant 0; inst_size  out  2  constant 2'b10.
REQ-011 inst_addr  out  32  bus address; inst_addr_ok  in  1  address accepted; inst_data_ok  in  1  read data valid; inst_rdata  in  32  read data.
REQ-012 inst_addr_err  out  1  one-cycle pulse, misaligned fetch; inst_timeout  out  1  one-cycle pulse, bus timeout.

Function
REQ-013 FSM states are IDLE, REQ, WAIT, DONE; one transaction outstanding at most.
REQ-014 IDLE: when interface_enable=1, latch interface_PC into pc_q and go to REQ, or to DONE if interface_PC[1:0]!=0.
REQ-015 cache_wait_stop_choke = interface_enable in IDLE, 1 in REQ and WAIT, 0 in DONE.
REQ-016 REQ: inst_req=1, inst_addr=pc_q; on inst_addr_ok go to WAIT; if inst_addr_ok and inst_data_ok in the same cycle, capture inst_rdata and go to DONE.
REQ-017 WAIT: inst_req=0; on inst_data_ok capture inst_rdata into rdata_q and go to DONE.
REQ-018 DONE lasts exactly one cycle: this_time_pc=pc_q, interface_instruction=rdata_q, then return to IDLE unconditionally.
REQ-019 Outside DONE: this_time_pc=interface_PC, interface_instruction=rdata_q.
REQ-020 Minimum miss latency: 3 cycles from interface_enable rise to the DONE cycle (IDLE, REQ, DONE).
REQ-021 Misaligned PC: issues no bus request; the DONE cycle delivers interface_instruction=32'h0 and pulses inst_addr_err.
REQ-022 inst_data_ok arriving in IDLE, REQ (without addr_ok), or DONE is ignored; rdata_q is unchanged.
REQ-023 A change of interface_PC during REQ or WAIT is ignored; pc_q is held until DONE.

Reset
REQ-024 Reset forces state IDLE, pc_q=0, rdata_q=0, and the timeout counter to 0.
REQ-025 While reset=1: inst_req=0, inst_addr_err=0, inst_timeout=0, cache_wait_stop_choke=0.
REQ-026 Reset in mid-transaction abandons the transaction; a late inst_data_ok after reset is discarded per REQ-022.

Configuration
REQ-027 Macro INST_IF_TIMEOUT_EN defined:
  - an 8-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT;
  - when the counter reaches TIMEOUT_CYCLES, go to DONE with rdata_q=32'h0 and pulse inst_timeout in the DONE cycle.
REQ-028 Macro INST_IF_TIMEOUT_EN undefined: no counter exists, inst_timeout is tied 0, and REQ/WAIT wait indefinitely.

Structure
REQ-029 Shared package inst_if_pkg holds:
  - the state enumeration (IDLE, REQ, WAIT, DONE);
  - INST_SIZE_WORD=2'b10;
  - INST_NOP=32'h0;
  - the TIMEOUT_CYCLES default.
REQ-030 One sub-module, inst_if_watchdog, implements the timeout counter; it is instantiated only under INST_IF_TIMEOUT_EN.

Verification
REQ-031 Miss at PC=0x00400010; addr_ok on the 1st REQ cycle; data_ok with rdata=0x3C1D0040 two cycles later -> DONE delivers this_time_pc=0x00400010 and instruction=0x3C1D0040; choke is 1 every cycle before DONE.
REQ-032 Miss at PC=0x00400020 with addr_ok and data_ok together (rdata=0x27BDFFE8) -> DONE 3 cycles after enable rises; inst_req high for exactly 1 cycle.
REQ-033 Miss at PC=0x00400022 -> inst_req never asserts; DONE delivers 32'h0 with inst_addr_err=1 for 1 cycle.
REQ-034 Reset asserted in WAIT, then data_ok pulsed -> state IDLE; rdata_q=0; no DONE cycle occurs.
REQ-035 INST_IF_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no addr_ok -> DONE after 4 REQ cycles with inst_timeout=1 and instruction=32'h0; without the macro, inst_req stays high for 100+ cycles.
